// File: rtl/uart_rx_stream.sv
// uart_rx_stream: parametrised UART receiver with parity/stop checking,
// error pulses and a small valid/ready output FIFO.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision is the 2-of-3
// majority of synced rx at mid-1, mid and mid+1 (decided at mid+1).
module uart_rx_stream #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rstN,
    input  logic                               rx,
    output logic [DATA_BITS-1:0]               m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               busy,
    output logic                               frame_err,
    output logic                               parity_err,
    output logic                               overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_LAG = 1;
`else
    localparam int SAMPLE_LAG = 0;
`endif

    // Start sample at mid-bit (one cycle later when voting); later samples are one bit period apart.
    localparam logic [TW-1:0] T_START = TW'(CLKS_PER_BIT / 2 - 1 + SAMPLE_LAG);
    localparam logic [TW-1:0] T_BIT   = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                 rx_s1_q, rx_s1_d;
    logic                 rx_s2_q, rx_s2_d;
    logic                 rx_prev_q, rx_prev_d;
    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_flag_q, par_flag_d;
    logic                 frm_flag_q, frm_flag_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic sample_bit;
    logic push, do_push, pop, full, frm_now, par_exp;

`ifdef UART_RX_MAJORITY_EN
    logic rx_old_q, rx_old_d;
    // 2-of-3 vote over the last three synced samples.
    always_comb begin
        rx_old_d   = rx_prev_q;
        sample_bit = (rx_s2_q & rx_prev_q) | (rx_s2_q & rx_old_q) | (rx_prev_q & rx_old_q);
    end
`else
    // Single mid-bit sample.
    always_comb begin
        sample_bit = rx_s2_q;
    end
`endif

    // Next-state logic for the receive FSM and the output FIFO.
    always_comb begin
        rx_s1_d      = rx;
        rx_s2_d      = rx_s1_q;
        rx_prev_d    = rx_s2_q;
        state_d      = state_q;
        timer_d      = timer_q + TW'(1);
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        par_flag_d   = par_flag_q;
        frm_flag_d   = frm_flag_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push         = 1'b0;
        frm_now      = frm_flag_q | ~sample_bit;
        par_exp      = (^shift_q) ^ (PARITY_MODE == 2);

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (rx_prev_q && !rx_s2_q) begin
                    state_d    = S_START;
                    par_flag_d = 1'b0;
                    frm_flag_d = 1'b0;
                end
            end
            S_START: begin
                if (timer_q == T_START) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = sample_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer_q == T_BIT) begin
                    timer_d = '0;
                    shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (timer_q == T_BIT) begin
                    timer_d    = '0;
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                    if (sample_bit != par_exp) par_flag_d = 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == T_BIT) begin
                    timer_d = '0;
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d      = S_IDLE;
                        frame_err_d  = frm_now;
                        parity_err_d = par_flag_q;
                        push         = ~frm_now & ~par_flag_q;
                    end else begin
                        frm_flag_d = frm_now;
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);

        // A pop at full frees the slot the simultaneous push needs.
        full      = (count_q == CW'(FIFO_DEPTH));
        pop       = (count_q != '0) & m_ready;
        do_push   = push & (~full | pop);
        overrun_d = push & full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(pop);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            rx_old_q     <= 1'b1;
`endif
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            par_flag_q   <= 1'b0;
            frm_flag_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            rx_s1_q      <= rx_s1_d;
            rx_s2_q      <= rx_s2_d;
            rx_prev_q    <= rx_prev_d;
`ifdef UART_RX_MAJORITY_EN
            rx_old_q     <= rx_old_d;
`endif
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            par_flag_q   <= par_flag_d;
            frm_flag_q   <= frm_flag_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign m_data     = mem_q[rd_ptr_q];
    assign m_valid    = (count_q != '0);
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream: 8N1 instance plus an odd-parity instance.
module tb_uart_rx_stream;

    localparam int CPB = 32;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [2:0] fifo_count;
    logic       busy, frame_err, parity_err, overrun;

    logic       rx_p = 1'b1;
    logic       ready_p = 1'b1;
    logic [7:0] p_data;
    logic       p_valid;
    logic [2:0] p_count;
    logic       p_busy, p_ferr, p_perr, p_ovr;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_p[$];
    int n_ferr = 0, n_perr = 0, n_ovr = 0;
    int np_ferr = 0, np_perr = 0, np_ovr = 0;

    always #5 clk = ~clk;

    uart_rx_stream #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .rstN(rstN), .rx(rx), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_count(fifo_count), .busy(busy),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    uart_rx_stream #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_par (
        .clk(clk), .rstN(rstN), .rx(rx_p), .m_data(p_data), .m_valid(p_valid),
        .m_ready(ready_p), .fifo_count(p_count), .busy(p_busy),
        .frame_err(p_ferr), .parity_err(p_perr), .overrun(p_ovr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboards on each accepted word and counts error pulses.
    always @(negedge clk) begin
        if (rstN) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL word: got unexpected 0x%0h, none required", m_data);
                end else begin
                    check("word", m_data, exp_q.pop_front());
                end
            end
            if (p_valid && ready_p) begin
                if (exp_p.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pword: got unexpected 0x%0h, none required", p_data);
                end else begin
                    check("pword", p_data, exp_p.pop_front());
                end
            end
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
            if (overrun)    n_ovr++;
            if (p_ferr)     np_ferr++;
            if (p_perr)     np_perr++;
            if (p_ovr)      np_ovr++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit which, input logic b);
        if (which) rx_p = b; else rx = b;
        idle(CPB);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop_bit);
        drive(which, 1'b0);
        for (int i = 0; i < 8; i++) drive(which, d[i]);
        if (par_en) drive(which, par_bit);
        drive(which, stop_bit);
        if (which) rx_p = 1'b1; else rx = 1'b1;
    endtask

    task automatic wait_drain(input bit which, input int limit);
        for (int i = 0; i < limit; i++) begin
            if ((which ? exp_p.size() : exp_q.size()) == 0) break;
            idle(1);
        end
        check(which ? "pdrain" : "drain", which ? exp_p.size() : exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        idle(3);
        rstN = 1'b1;
        check("rst_valid", m_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_data", m_data, 0);
        check("rst_pulses", {frame_err, parity_err, overrun}, 0);

        // Plain 8N1 word with consumer ready.
        m_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        idle(5);
        wait_drain(0, 20);
        check("a5_ferr", n_ferr, 0);
        check("a5_perr", n_perr, 0);

        // Bad stop bit, then a clean frame.
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        idle(5);
        check("3c_ferr", n_ferr, 1);
        check("3c_count", fifo_count, 0);
        idle(CPB);
        exp_q.push_back(8'h55);
        send_frame(0, 8'h55, 0, 1'b0, 1'b1);
        idle(5);
        wait_drain(0, 20);
        check("55_ferr", n_ferr, 1);

        // Backpressure: five back-to-back frames into a 4-deep FIFO.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) send_frame(0, 8'h10 + 8'(i), 0, 1'b0, 1'b1);
        idle(5);
        check("full_count", fifo_count, 4);
        check("full_ovr", n_ovr, 1);
        check("full_head", m_data, 8'h10);
        check("full_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_drain(0, 20);
        idle(2);
        check("drain_count", fifo_count, 0);
        check("drain_ovr", n_ovr, 1);

        // Short low glitch is a false start.
        rx = 1'b0;
        idle(10);
        check("glitch_busy_hi", busy, 1);
        rx = 1'b1;
        idle(40);
        check("glitch_busy_lo", busy, 0);
        check("glitch_count", fifo_count, 0);
        check("glitch_ferr", n_ferr, 1);
        check("glitch_perr", n_perr, 0);

        // Reset mid-frame with a word already buffered.
        m_ready = 1'b0;
        send_frame(0, 8'h42, 0, 1'b0, 1'b1);
        idle(5);
        check("pre_rst_count", fifo_count, 1);
        d = 8'h99;
        drive(0, 1'b0);
        for (int i = 0; i < 3; i++) drive(0, d[i]);
        rx = d[3];
        idle(CPB / 2);
        rx = 1'b1;
        rstN = 1'b0;
        idle(1);
        rstN = 1'b1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", m_data, 0);
        m_ready = 1'b1;
        idle(CPB);
        exp_q.push_back(8'h7E);
        send_frame(0, 8'h7E, 0, 1'b0, 1'b1);
        idle(5);
        wait_drain(0, 20);
        check("7e_ferr", n_ferr, 1);
        check("7e_ovr", n_ovr, 1);

        // Odd parity: 0x01 needs parity 0, 0x03 needs parity 1.
        send_frame(1, 8'h01, 1, 1'b1, 1'b1);
        idle(5);
        check("p01_bad_perr", np_perr, 1);
        check("p01_bad_count", p_count, 0);
        exp_p.push_back(8'h01);
        send_frame(1, 8'h01, 1, 1'b0, 1'b1);
        exp_p.push_back(8'h03);
        send_frame(1, 8'h03, 1, 1'b1, 1'b1);
        idle(5);
        wait_drain(1, 20);
        check("p_perr_final", np_perr, 1);
        check("p_ferr_final", np_ferr, 0);
        check("p_ovr_final", np_ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
